// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
// Default widths match the memory controller IF port (32-bit words, 16-deep).
package fetch_pkg;

    localparam int FETCH_DATA_W    = 32;
    localparam int FETCH_DEPTH     = 16;
    localparam int FETCH_POS_W     = $clog2(FETCH_DEPTH);
    localparam int FETCH_FBDEPTH   = 2;
    localparam int FETCH_RESET_POS = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] data;
        logic [FETCH_POS_W-1:0]  pos;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO with registered head (push visible next cycle), clear wins over push/pop.
// No internal backpressure: push when full is accepted only alongside a pop; pop when empty is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = FETCH_FBDEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  entry_t        push_dat_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    entry_t        mem_q [DEPTH];
    entry_t        head_q, head_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d, count_kept;
    logic          pop_ok, push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        head_d     = head_q;
        count_kept = count_q - CW'(pop_ok);
        if (clear_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            head_d  = '0;
        end else begin
            rd_d    = rd_q + PW'(pop_ok);
            wr_d    = wr_q + PW'(push_ok);
            count_d = count_kept + CW'(push_ok);
            // Head is recomputed ahead of time so instr_o comes straight from a flop.
            if (count_d == '0) begin
                head_d = '0;
            end else if (count_kept == '0) begin
                head_d = push_dat_i;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding IF read, words reach decode 1 cycle after if_read_valid_i; redirect flushes/squashes.
// Stops requesting when buffer + in-flight would exceed FBDEPTH; FETCH_PERF_EN adds fetch/stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int  MEMDATAWIDTH = FETCH_DATA_W,
    parameter int  MEMDEPTH     = FETCH_DEPTH,
    parameter int  FBDEPTH      = FETCH_FBDEPTH,
    parameter int  RESET_POS    = FETCH_RESET_POS,
    localparam int MD           = $clog2(MEMDEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    if_read_en_o,
    output logic [MD-1:0]           if_read_pos_o,
    input  logic [MEMDATAWIDTH-1:0] if_read_data_i,
    input  logic                    if_read_valid_i,
    input  logic                    redirect_i,
    input  logic [MD-1:0]           redirect_pos_i,
    output logic [MEMDATAWIDTH-1:0] instr_o,
    output logic [MD-1:0]           instr_pos_o,
    output logic                    instr_valid_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]             fetch_count_o,
    output logic [31:0]             stall_count_o,
`endif
    input  logic                    instr_ready_i
);

    localparam int CW = $clog2(FBDEPTH + 1);

    typedef struct packed {
        logic [MEMDATAWIDTH-1:0] data;
        logic [MD-1:0]           pos;
    } entry_t;

    fetch_state_e  state_q, state_d;
    logic [MD-1:0] pc_q, pc_d, pos_q, pos_d, pc_inc;
    logic          en_q, en_d;
    logic          push, pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ_kept;
    logic          fifo_full, fifo_empty, room_after_push;
    entry_t        push_dat, head;

    assign pop             = instr_valid_o && instr_ready_i;
    assign pc_inc          = pc_q + MD'(1);
    assign occ_kept        = {1'b0, fifo_count} - (CW+1)'(pop);
    assign room_after_push = (occ_kept + (CW+1)'(1)) < (CW+1)'(FBDEPTH);
    assign push_dat        = entry_t'{data: if_read_data_i, pos: pc_q};

    fetch_fifo #(
        .DEPTH   (FBDEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (redirect_i),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pos_d   = pos_q;
        en_d    = en_q;
        push    = 1'b0;
        if (redirect_i) begin
            pc_d = redirect_pos_i;
            // A read already presented to the controller must still be completed, then dropped.
            if (state_q != IDLE && !if_read_valid_i) begin
                state_d = SQUASH;
            end else begin
                state_d = REQ;
                en_d    = 1'b1;
                pos_d   = redirect_pos_i;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_full || pop) begin
                        state_d = REQ;
                        en_d    = 1'b1;
                        pos_d   = pc_q;
                    end
                end
                REQ: begin
                    if (if_read_valid_i) begin
                        push = 1'b1;
                        pc_d = pc_inc;
                        if (room_after_push) begin
                            pos_d = pc_inc;
                        end else begin
                            state_d = IDLE;
                            en_d    = 1'b0;
                        end
                    end
                end
                SQUASH: begin
                    if (if_read_valid_i) begin
                        state_d = REQ;
                        pos_d   = pc_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= MD'(RESET_POS);
            pos_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pos_q   <= pos_d;
            en_q    <= en_d;
        end
    end

    assign if_read_en_o  = en_q;
    assign if_read_pos_o = pos_q;
    assign instr_o       = head.data;
    assign instr_pos_o   = head.pos;
    assign instr_valid_o = !fifo_empty;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (state_q != IDLE && !if_read_valid_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small IF-port responder (programmable arbitration stall).
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        if_read_en_o;
    logic [3:0]  if_read_pos_o;
    logic [31:0] if_read_data_i;
    logic        if_read_valid_i;
    logic        redirect_i;
    logic [3:0]  redirect_pos_i;
    logic [31:0] instr_o;
    logic [3:0]  instr_pos_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_o;
    logic [31:0] stall_count_o;
`endif

    fetch_unit #(
        .MEMDATAWIDTH (32),
        .MEMDEPTH     (16),
        .FBDEPTH      (2),
        .RESET_POS    (1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .if_read_en_o    (if_read_en_o),
        .if_read_pos_o   (if_read_pos_o),
        .if_read_data_i  (if_read_data_i),
        .if_read_valid_i (if_read_valid_i),
        .redirect_i      (redirect_i),
        .redirect_pos_i  (redirect_pos_i),
        .instr_o         (instr_o),
        .instr_pos_o     (instr_pos_o),
        .instr_valid_o   (instr_valid_o),
`ifdef FETCH_PERF_EN
        .fetch_count_o   (fetch_count_o),
        .stall_count_o   (stall_count_o),
`endif
        .instr_ready_i   (instr_ready_i)
    );

    int          n_assert;
    int          n_fail;
    int          stall_cycles;
    int          wait_cnt;
    logic [31:0] mem [16];
    logic [31:0] pop_dat [$];
    logic [3:0]  pop_pos [$];
    logic [3:0]  req_pos [$];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    // Controller model: answers a held request after stall_cycles waiting cycles with a 1-cycle valid.
    initial begin
        if_read_valid_i = 1'b0;
        if_read_data_i  = '0;
        wait_cnt        = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (if_read_valid_i) begin
                if_read_valid_i = 1'b0;
                if_read_data_i  = '0;
                wait_cnt        = 0;
            end else if (rst_ni && if_read_en_o) begin
                if (wait_cnt >= stall_cycles) begin
                    if_read_valid_i = 1'b1;
                    if_read_data_i  = mem[if_read_pos_o];
                    req_pos.push_back(if_read_pos_o);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && instr_valid_o && instr_ready_i) begin
                pop_dat.push_back(instr_o);
                pop_pos.push_back(instr_pos_o);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pd(input int i);
        if (i < pop_dat.size()) return pop_dat[i];
        return 'x;
    endfunction

    function automatic logic [3:0] pp(input int i);
        if (i < pop_pos.size()) return pop_pos[i];
        return 'x;
    endfunction

    function automatic logic [3:0] rp(input int i);
        if (i < req_pos.size()) return req_pos[i];
        return 'x;
    endfunction

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA500_0000 + 32'(i);
        mem[1] = 32'd1;
        mem[2] = 32'd2;
        mem[3] = 32'd3;
        rst_ni         = 1'b0;
        instr_ready_i  = 1'b0;
        redirect_i     = 1'b0;
        redirect_pos_i = '0;

        // Reset state
        cyc(2);
        chk("rst_en", if_read_en_o, 0);
        chk("rst_rpos", if_read_pos_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_ipos", instr_pos_o, 0);
`ifdef FETCH_PERF_EN
        chk("rst_fetch_cnt", fetch_count_o, 0);
        chk("rst_stall_cnt", stall_count_o, 0);
`endif

        // First request one cycle after release, first word one cycle after valid
        rst_ni = 1'b1;
        cyc(1);
        chk("lat_en", if_read_en_o, 1);
        chk("lat_rpos", if_read_pos_o, 1);
        chk("lat_valid0", instr_valid_o, 0);
        cyc(1);
        chk("lat_valid1", instr_valid_o, 1);
        chk("lat_instr", instr_o, 32'd1);
        chk("lat_ipos", instr_pos_o, 1);
        chk("lat_rpos2", if_read_pos_o, 2);
        chk("lat_en2", if_read_en_o, 1);

        // Backpressure: decode stalled, exactly two words buffered and requests stop
        cyc(6);
        chk("bp_en", if_read_en_o, 0);
        chk("bp_valid", instr_valid_o, 1);
        chk("bp_head", instr_o, 32'd1);
        chk("bp_nreq", req_pos.size(), 2);

        // Resume and sequential delivery
        instr_ready_i = 1'b1;
        cyc(1);
        chk("res_en", if_read_en_o, 1);
        chk("res_rpos", if_read_pos_o, 3);
        cyc(10);
        chk("seq_d0", pd(0), 32'd1);
        chk("seq_p0", pp(0), 1);
        chk("seq_d1", pd(1), 32'd2);
        chk("seq_p1", pp(1), 2);
        chk("seq_d2", pd(2), 32'd3);
        chk("seq_p2", pp(2), 3);
        chk("seq_r0", rp(0), 1);
        chk("seq_r1", rp(1), 2);
        chk("seq_r2", rp(2), 3);
        chk("seq_r3", rp(3), 4);
        instr_ready_i = 1'b0;
        cyc(10);

        // Arbitration stall: redirect to 0 from idle, controller holds off 3 cycles
        pop_dat.delete();
        pop_pos.delete();
        stall_cycles   = 3;
        redirect_i     = 1'b1;
        redirect_pos_i = 4'd0;
        cyc(1);
        redirect_i = 1'b0;
        chk("stl_en0", if_read_en_o, 1);
        chk("stl_rpos0", if_read_pos_o, 0);
        chk("stl_valid0", instr_valid_o, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("stl_en_hold", if_read_en_o, 1);
            chk("stl_rpos_hold", if_read_pos_o, 0);
        end
        cyc(1);
        chk("stl_valid", instr_valid_o, 1);
        chk("stl_ipos", instr_pos_o, 0);
        chk("stl_instr", instr_o, 32'hA500_0000);
        chk("stl_rpos_next", if_read_pos_o, 1);
        cyc(7);
        chk("stl_full_en", if_read_en_o, 0);
        instr_ready_i = 1'b1;
        cyc(2);
        instr_ready_i = 1'b0;
        stall_cycles  = 1000;
        chk("stl_npop", pop_pos.size(), 2);
        chk("stl_pop_p0", pp(0), 0);
        chk("stl_pop_p1", pp(1), 1);
        chk("stl_pop_d1", pd(1), 32'd1);

        // Redirect while the read of pos 2 is pending
        cyc(3);
        chk("rd_pend_en", if_read_en_o, 1);
        chk("rd_pend_rpos", if_read_pos_o, 2);
        redirect_i     = 1'b1;
        redirect_pos_i = 4'd7;
        cyc(1);
        redirect_i   = 1'b0;
        stall_cycles = 0;
        chk("sq_en", if_read_en_o, 1);
        chk("sq_rpos", if_read_pos_o, 2);
        chk("sq_valid", instr_valid_o, 0);
        cyc(1);
        chk("sq_done_en", if_read_en_o, 1);
        chk("sq_done_rpos", if_read_pos_o, 7);
        chk("sq_done_valid", instr_valid_o, 0);
        cyc(2);
        chk("rd_valid", instr_valid_o, 1);
        chk("rd_ipos", instr_pos_o, 7);
        chk("rd_instr", instr_o, 32'hA500_0007);

        // Position wrap 15 -> 0
        cyc(4);
        pop_dat.delete();
        pop_pos.delete();
        redirect_i     = 1'b1;
        redirect_pos_i = 4'd15;
        cyc(1);
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        cyc(1);
        chk("wr_ipos", instr_pos_o, 15);
        chk("wr_instr", instr_o, 32'hA500_000F);
        chk("wr_rpos", if_read_pos_o, 0);
        cyc(6);
        chk("wr_pop_p0", pp(0), 15);
        chk("wr_pop_p1", pp(1), 0);
        chk("wr_pop_d1", pd(1), 32'hA500_0000);

        // Asynchronous reset in the middle of a pending request
        stall_cycles = 1000;
        cyc(4);
        chk("ar_pre_en", if_read_en_o, 1);
        rst_ni        = 1'b0;
        instr_ready_i = 1'b0;
        stall_cycles  = 0;
        #1;
        chk("ar_en", if_read_en_o, 0);
        chk("ar_rpos", if_read_pos_o, 0);
        chk("ar_valid", instr_valid_o, 0);
        chk("ar_instr", instr_o, 0);
        chk("ar_ipos", instr_pos_o, 0);
`ifdef FETCH_PERF_EN
        chk("ar_fetch_cnt", fetch_count_o, 0);
        chk("ar_stall_cnt", stall_count_o, 0);
`endif
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);
        chk("ar_rel_en", if_read_en_o, 1);
        chk("ar_rel_rpos", if_read_pos_o, 1);
        cyc(1);
        chk("ar_rel_valid", instr_valid_o, 1);
        chk("ar_rel_ipos", instr_pos_o, 1);
        chk("ar_rel_instr", instr_o, 32'd1);
`ifdef FETCH_PERF_EN
        chk("ar_rel_fetch_cnt", fetch_count_o, 1);
        chk("ar_rel_stall_cnt", stall_count_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
